branch_unit: RTL and testbench

Parametrised successor to the ARM7 branch block. It executes B, BL, BX and BLX (register) on a condition flag, using the shared single read/write register_file ports. PC and Rm are fetched through the read port, and LR and PC are updated through the write port. It runs as a multi-cycle FSM with a start/busy/done handshake and sits between the decoder and register_file in the arm7 core.

---
 rtl/branch_unit_pkg.sv | 37 +++
 rtl/branch_unit_target_calc.sv | 48 ++++
 rtl/branch_unit.sv | 200 ++++++++++++++++++++
 tb/tb_branch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_unit_pkg
// Shared arm7 definitions used by the branch unit and its target calculator:
//   - br_mode_e  : branch mode encoding carried on the 'mode' input
//   - br_state_e : branch FSM state encoding
//   - register index and pipeline offset defaults
//   - is_exchange: true for the register-target (BX/BLX) modes
// ---------------------------------------------------------------------------
package branch_unit_pkg;

  typedef enum logic [1:0] {
    BR_B   = 2'b00,
    BR_BL  = 2'b01,
    BR_BX  = 2'b10,
    BR_BLX = 2'b11
  } br_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_PC,
    ST_WAIT_PC,
    ST_RD_RM,
    ST_WAIT_RM,
    ST_WR_LR,
    ST_WR_PC,
    ST_DONE
  } br_state_e;

  localparam int unsigned PC_REG_DEF   = 15;
  localparam int unsigned LR_REG_DEF   = 14;
  localparam int unsigned PIPE_OFS_DEF = 8;

  function automatic logic is_exchange(input br_mode_e m);
    return (m == BR_BX) || (m == BR_BLX);
  endfunction

endpackage

// File: rtl/branch_unit_target_calc.sv
// ---------------------------------------------------------------------------
// branch_target_calc
// Combinational branch arithmetic, generic in ADDR_W (all results mod 2^ADDR_W).
// Ports:
//   pc       in  ADDR_W  current PC value as read from the register file
//   offset   in  24      signed word offset of B/BL
//   rm_value in  ADDR_W  Rm value for BX/BLX
//   mode     in  2       branch mode
//   next_pc  out ADDR_W  PC+PIPE_OFS+(sext(offset)<<2), or Rm with bit 0 cleared
//   link     out ADDR_W  PC+4 (return address, also the not-taken PC)
//   thumb    out 1       Rm[0] for BX/BLX, 0 otherwise
// ---------------------------------------------------------------------------
module branch_target_calc
  import branch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned PIPE_OFS = PIPE_OFS_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [23:0]       offset,
  input  logic [ADDR_W-1:0] rm_value,
  input  br_mode_e          mode,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] link,
  output logic              thumb
);

  logic signed [25:0] ofs_bytes;
  logic [ADDR_W-1:0]  ofs_addr;
  logic               exchange;

  // Word offset scaled to bytes; the signed size cast sign-extends for wide
  // address spaces and simply truncates for narrow ones.
  assign ofs_bytes = {offset, 2'b00};
  assign ofs_addr  = ADDR_W'(ofs_bytes);
  assign exchange  = is_exchange(mode);

  // Register-target branches ignore the offset and force a halfword-aligned PC.
  always_comb begin
    next_pc = pc + ADDR_W'(PIPE_OFS) + ofs_addr;
    if (exchange) begin
      next_pc = {rm_value[ADDR_W-1:1], 1'b0};
    end
    link  = pc + ADDR_W'(4);
    thumb = exchange & rm_value[0];
  end

endmodule

// File: rtl/branch_unit.sv
// ---------------------------------------------------------------------------
// branch_unit
// Multi-cycle B/BL/BX/BLX executor between the decoder and register_file.
// Reads PC (and Rm for BX/BLX) through the shared read port, then writes LR
// (link forms, taken only) followed by PC through the shared write port.
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   start                      request pulse, accepted only while busy=0
//   mode, cond, offset, rm     operation fields, latched at accept
//   busy                       accept edge through the done cycle
//   done                       one-cycle completion pulse
//   thumb_valid, thumb         taken BX/BLX: pulse with done, Rm[0] held
//   write_en/write_reg/write_value  register_file write port
//   read_en/read_reg/read_value     register_file read port
// ---------------------------------------------------------------------------
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned PC_REG   = PC_REG_DEF,
  parameter int unsigned LR_REG   = LR_REG_DEF,
  parameter int unsigned PIPE_OFS = PIPE_OFS_DEF,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              cond,
  input  logic [23:0]       offset,
  input  logic [3:0]        rm,
  output logic              busy,
  output logic              done,
  output logic              thumb_valid,
  output logic              thumb,
  output logic              write_en,
  output logic [3:0]        write_reg,
  output logic [ADDR_W-1:0] write_value,
  output logic              read_en,
  output logic [3:0]        read_reg,
  input  logic [ADDR_W-1:0] read_value
);

  localparam int unsigned CNT_W    = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LAT);
  localparam logic [3:0] PC_IDX = 4'(PC_REG);
  localparam logic [3:0] LR_IDX = 4'(LR_REG);

  br_state_e         state;
  br_mode_e          mode_q;
  logic              cond_q;
  logic [23:0]       offset_q;
  logic [3:0]        rm_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_target_q;
  logic              thumb_q;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] calc_pc;
  logic [ADDR_W-1:0] calc_next_pc;
  logic [ADDR_W-1:0] calc_link;
  logic              calc_thumb;
  logic              exch_taken;

  // While waiting on PC the arithmetic runs straight off the read port so the
  // first write can be issued on the capture edge; later it uses the saved PC.
  assign calc_pc    = (state == ST_WAIT_PC) ? read_value : pc_q;
  assign exch_taken = cond_q & is_exchange(mode_q);

  branch_target_calc #(
    .ADDR_W  (ADDR_W),
    .PIPE_OFS(PIPE_OFS)
  ) u_calc (
    .pc      (calc_pc),
    .offset  (offset_q),
    .rm_value(read_value),
    .mode    (mode_q),
    .next_pc (calc_next_pc),
    .link    (calc_link),
    .thumb   (calc_thumb)
  );

  // Single FSM with registered outputs. Strobes (read_en, write_en, done,
  // thumb_valid) default low each cycle so each one lasts exactly one cycle.
  // The read counter is loaded on the edge that raises read_en and data is
  // captured READ_LAT+1 edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      thumb_valid <= 1'b0;
      thumb       <= 1'b0;
      write_en    <= 1'b0;
      write_reg   <= '0;
      write_value <= '0;
      read_en     <= 1'b0;
      read_reg    <= '0;
      mode_q      <= BR_B;
      cond_q      <= 1'b0;
      offset_q    <= '0;
      rm_q        <= '0;
      pc_q        <= '0;
      pc_target_q <= '0;
      thumb_q     <= 1'b0;
      cnt         <= '0;
    end else begin
      write_en    <= 1'b0;
      read_en     <= 1'b0;
      done        <= 1'b0;
      thumb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q   <= br_mode_e'(mode);
            cond_q   <= cond;
            offset_q <= offset;
            rm_q     <= rm;
            busy     <= 1'b1;
            read_en  <= 1'b1;
            read_reg <= PC_IDX;
            cnt      <= LAT_INIT;
            state    <= ST_RD_PC;
          end
        end
        ST_RD_PC: begin
          cnt   <= cnt - 1'b1;
          state <= ST_WAIT_PC;
        end
        ST_WAIT_PC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            pc_q <= read_value;
            if (!cond_q || mode_q == BR_B) begin
              write_en    <= 1'b1;
              write_reg   <= PC_IDX;
              write_value <= cond_q ? calc_next_pc : calc_link;
              state       <= ST_WR_PC;
            end else if (mode_q == BR_BL) begin
              write_en    <= 1'b1;
              write_reg   <= LR_IDX;
              write_value <= calc_link;
              pc_target_q <= calc_next_pc;
              state       <= ST_WR_LR;
            end else begin
              read_en  <= 1'b1;
              read_reg <= rm_q;
              cnt      <= LAT_INIT;
              state    <= ST_RD_RM;
            end
          end
        end
        ST_RD_RM: begin
          cnt   <= cnt - 1'b1;
          state <= ST_WAIT_RM;
        end
        ST_WAIT_RM: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            thumb_q <= calc_thumb;
            if (mode_q == BR_BLX) begin
              write_en    <= 1'b1;
              write_reg   <= LR_IDX;
              write_value <= calc_link;
              pc_target_q <= calc_next_pc;
              state       <= ST_WR_LR;
            end else begin
              write_en    <= 1'b1;
              write_reg   <= PC_IDX;
              write_value <= calc_next_pc;
              state       <= ST_WR_PC;
            end
          end
        end
        ST_WR_LR: begin
          write_en    <= 1'b1;
          write_reg   <= PC_IDX;
          write_value <= pc_target_q;
          state       <= ST_WR_PC;
        end
        ST_WR_PC: begin
          done <= 1'b1;
          if (exch_taken) begin
            thumb_valid <= 1'b1;
            thumb       <= thumb_q;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_unit
// Drives two branch_unit instances (32-bit/READ_LAT=1 and 16-bit/READ_LAT=3)
// through a shared stimulus bus selected by 'sel'. Each instance has its own
// register_file model. Expected register writes are queued when an operation
// is launched and popped as the DUT writes; latency and thumb are checked at
// done.
// ---------------------------------------------------------------------------
module tb_branch_unit;

  localparam int RL_A = 1;
  localparam int RL_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, cond, sel;
  logic [1:0]  mode;
  logic [23:0] offset;
  logic [3:0]  rm;
  logic        start_a, start_b;

  logic        a_busy, a_done, a_tv, a_thumb, a_we, a_re;
  logic [3:0]  a_wr, a_rr;
  logic [31:0] a_wv, a_rv;
  logic        b_busy, b_done, b_tv, b_thumb, b_we, b_re;
  logic [3:0]  b_wr, b_rr;
  logic [15:0] b_wv, b_rv;

  logic        o_busy, o_done, o_tv, o_thumb, o_we, o_re;
  logic [3:0]  o_wr;
  logic [31:0] o_wv;

  logic        pre_en;
  logic [3:0]  pre_reg;
  logic [31:0] pre_val;

  logic [31:0] regs_a [16];
  logic [15:0] regs_b [16];
  logic [31:0] pipe_a [RL_A];
  logic [15:0] pipe_b [RL_B];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  r;
    logic [31:0] v;
  } wr_t;
  wr_t  exp_q[$];
  logic thumb_hold [2];

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign o_busy = sel ? b_busy  : a_busy;
  assign o_done = sel ? b_done  : a_done;
  assign o_tv   = sel ? b_tv    : a_tv;
  assign o_thumb= sel ? b_thumb : a_thumb;
  assign o_we   = sel ? b_we    : a_we;
  assign o_re   = sel ? b_re    : a_re;
  assign o_wr   = sel ? b_wr    : a_wr;
  assign o_wv   = sel ? {16'h0000, b_wv} : a_wv;

  branch_unit #(.ADDR_W(32), .READ_LAT(RL_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode), .cond(cond),
    .offset(offset), .rm(rm), .busy(a_busy), .done(a_done),
    .thumb_valid(a_tv), .thumb(a_thumb), .write_en(a_we), .write_reg(a_wr),
    .write_value(a_wv), .read_en(a_re), .read_reg(a_rr), .read_value(a_rv)
  );

  branch_unit #(.ADDR_W(16), .READ_LAT(RL_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .cond(cond),
    .offset(offset), .rm(rm), .busy(b_busy), .done(b_done),
    .thumb_valid(b_tv), .thumb(b_thumb), .write_en(b_we), .write_reg(b_wr),
    .write_value(b_wv), .read_en(b_re), .read_reg(b_rr), .read_value(b_rv)
  );

  // Register file models: write on the edge, read data appears READ_LAT edges
  // after read_en is sampled; a garbage pattern otherwise exposes mistimed captures.
  assign a_rv = pipe_a[RL_A-1];
  assign b_rv = pipe_b[RL_B-1];

  always @(posedge clk) begin
    if (a_we) regs_a[a_wr] <= a_wv;
    else if (pre_en && !sel) regs_a[pre_reg] <= pre_val;
    pipe_a[0] <= a_re ? regs_a[a_rr] : 32'hA5A5_5A5A;
    for (int i = 1; i < RL_A; i++) pipe_a[i] <= pipe_a[i-1];
  end

  always @(posedge clk) begin
    if (b_we) regs_b[b_wr] <= b_wv;
    else if (pre_en && sel) regs_b[pre_reg] <= pre_val[15:0];
    pipe_b[0] <= b_re ? regs_b[b_rr] : 16'hA55A;
    for (int i = 1; i < RL_B; i++) pipe_b[i] <= pipe_b[i-1];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [23:0] off,
                                            input logic [31:0] mask);
    logic [31:0] so;
    so = {{8{off[23]}}, off} << 2;
    return (pc + 32'd8 + so) & mask;
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] r, input logic [31:0] v);
    pre_reg = r;
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clk);
    #1;
    pre_en  = 1'b0;
  endtask

  // Follows one operation from the accept edge to done, scoring every write.
  task automatic checkOutput(input string tag, input int lat, input bit tv);
    int  n;
    bit  got;
    wr_t e;
    n   = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      @(posedge clk);
      n++;
      #1;
      if (o_we) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("[TB] FAIL %s unexpected write: observed reg %0d expected none", tag, o_wr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkValue({tag, " write"}, 64'({o_wr, o_wv}), 64'({e.r, e.v}));
        end
      end
      if (o_done) begin
        got = 1'b1;
        checkValue({tag, " latency"}, 64'(n), 64'(lat));
        checkValue({tag, " thumb_valid"}, 64'(o_tv), 64'(tv));
        checkValue({tag, " thumb"}, 64'(o_thumb), 64'(thumb_hold[sel]));
        checkValue({tag, " busy at done"}, 64'(o_busy), 64'd1);
        checkValue({tag, " writes left"}, 64'(exp_q.size()), 64'd0);
      end
    end
    checkValue({tag, " done seen"}, 64'(got), 64'd1);
    exp_q.delete();
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] m, input logic c,
                               input logic [23:0] off, input logic [3:0] r,
                               input logic [31:0] pc_val, input logic [31:0] rm_val,
                               input bit poke);
    int          rl, lat;
    bit          tv;
    logic [31:0] mask, pcv, rmv, link, tgt;
    rl   = sel ? RL_B : RL_A;
    mask = sel ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    pcv  = pc_val & mask;
    preload(4'd15, pcv);
    if (r != 4'd15) preload(r, rm_val & mask);
    rmv  = (r == 4'd15) ? pcv : (rm_val & mask);
    link = (pcv + 32'd4) & mask;
    tgt  = br_target(pcv, off, mask);
    tv   = 1'b0;
    if (!c) begin
      exp_q.push_back(wr_t'{r: 4'd15, v: link});
      lat = rl + 2;
    end else begin
      case (m)
        2'b00: begin
          exp_q.push_back(wr_t'{r: 4'd15, v: tgt});
          lat = rl + 2;
        end
        2'b01: begin
          exp_q.push_back(wr_t'{r: 4'd14, v: link});
          exp_q.push_back(wr_t'{r: 4'd15, v: tgt});
          lat = rl + 3;
        end
        2'b10: begin
          exp_q.push_back(wr_t'{r: 4'd15, v: rmv & ~32'd1});
          lat = 2 * rl + 3;
          tv  = 1'b1;
        end
        default: begin
          exp_q.push_back(wr_t'{r: 4'd14, v: link});
          exp_q.push_back(wr_t'{r: 4'd15, v: rmv & ~32'd1});
          lat = 2 * rl + 4;
          tv  = 1'b1;
        end
      endcase
    end
    if (tv) thumb_hold[sel] = rmv[0];
    mode   = m;
    cond   = c;
    offset = off;
    rm     = r;
    start  = 1'b1;
    @(posedge clk);
    #1;
    checkValue({tag, " busy after accept"}, 64'(o_busy), 64'd1);
    if (!poke) start = 1'b0;
    mode   = ~m;
    cond   = ~c;
    offset = ~off;
    rm     = ~r;
    checkOutput(tag, lat, tv);
    if (poke) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      checkValue({tag, " idle"}, 64'({o_busy, o_we, o_re}), 64'd0);
    end
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    start   = 1'b0;
    sel     = 1'b0;
    mode    = 2'b00;
    cond    = 1'b0;
    offset  = '0;
    rm      = '0;
    pre_en  = 1'b0;
    pre_reg = '0;
    pre_val = '0;
    thumb_hold[0] = 1'b0;
    thumb_hold[1] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkValue("reset busy/done", 64'({a_busy, a_done, b_busy, b_done}), 64'd0);
    checkValue("reset thumb", 64'({a_tv, a_thumb, b_tv, b_thumb}), 64'd0);
    checkValue("reset write port a", 64'({a_we, a_wr, a_wv}), 64'd0);
    checkValue("reset read port a", 64'({a_re, a_rr}), 64'd0);
    checkValue("reset ports b", 64'({b_we, b_wr, b_wv, b_re, b_rr}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] 32-bit, READ_LAT=1");
    applyStimulus("b_not_taken", 2'b00, 1'b0, 24'd0,       4'd0,  32'h0000_1000, 32'h0, 1'b0);
    applyStimulus("b_taken",     2'b00, 1'b1, 24'd3,       4'd0,  32'h0000_1004, 32'h0, 1'b0);
    applyStimulus("bl_negative", 2'b01, 1'b1, 24'hFFFFFE,  4'd0,  32'h0000_2000, 32'h0, 1'b0);
    applyStimulus("blx_r3",      2'b11, 1'b1, 24'd0,       4'd3,  32'h0000_2000, 32'h0000_3001, 1'b0);
    applyStimulus("bx_r3",       2'b10, 1'b1, 24'd0,       4'd3,  32'h0000_3000, 32'h0000_4000, 1'b0);
    applyStimulus("b_wrap",      2'b00, 1'b1, 24'd1,       4'd0,  32'hFFFF_FFFC, 32'h0, 1'b0);
    applyStimulus("bx_pc",       2'b10, 1'b1, 24'd0,       4'd15, 32'h0000_5001, 32'h0, 1'b0);
    applyStimulus("bl_start_held", 2'b01, 1'b1, 24'd5,     4'd0,  32'h0000_7000, 32'h0, 1'b1);
    applyStimulus("bx_not_taken", 2'b10, 1'b0, 24'd0,      4'd3,  32'h0000_8000, 32'h0000_9001, 1'b0);

    $display("[TB] reset during BL");
    preload(4'd15, 32'h0000_6000);
    mode   = 2'b01;
    cond   = 1'b1;
    offset = 24'd0;
    rm     = 4'd0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(a_we && a_wr == 4'd14) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkValue("rst lr write", 64'({a_we, a_wr, a_wv}), 64'({1'b1, 4'd14, 32'h0000_6004}));
    @(posedge clk);
    #1;
    checkValue("rst pc write pending", 64'({a_we, a_wr}), 64'({1'b1, 4'd15}));
    rst_n = 1'b0;
    thumb_hold[0] = 1'b0;
    thumb_hold[1] = 1'b0;
    #1;
    checkValue("rst outputs", 64'({a_busy, a_done, a_tv, a_thumb, a_we, a_re, a_wr, a_rr}), 64'd0);
    checkValue("rst write value", 64'(a_wv), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    checkValue("rst lr kept", 64'(regs_a[14]), 64'h0000_6004);
    checkValue("rst pc untouched", 64'(regs_a[15]), 64'h0000_6000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("b_after_reset", 2'b00, 1'b1, 24'd2, 4'd0, 32'h0000_0100, 32'h0, 1'b0);

    $display("[TB] 16-bit, READ_LAT=3");
    sel = 1'b1;
    applyStimulus("w16_b_wrap",  2'b00, 1'b1, 24'd0,      4'd0, 32'h0000_FFF0, 32'h0, 1'b0);
    applyStimulus("w16_blx_r3",  2'b11, 1'b1, 24'd0,      4'd3, 32'h0000_0100, 32'h0000_1235, 1'b0);
    applyStimulus("w16_bx_nt",   2'b10, 1'b0, 24'd0,      4'd3, 32'h0000_2000, 32'h0000_0000, 1'b0);
    applyStimulus("w16_b_neg",   2'b00, 1'b1, 24'hFFFFFF, 4'd0, 32'h0000_0004, 32'h0, 1'b0);
    applyStimulus("w16_bl_held", 2'b01, 1'b1, 24'd1,      4'd0, 32'h0000_0200, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
